// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction memory and
// presents the captured byte to decode over a valid/ready handshake. HALT stop: FETCH_HALT_EN.
module fetch_unit #(
    parameter int unsigned     PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [7:0]      HALT_OPCODE = 8'hFF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_en_i,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic [7:0]      imem_data_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [7:0]      ir_o,
    output logic [PC_W-1:0] ir_pc_o,
    output logic            ir_valid_o,
    input  logic            ir_ready_i,
    output logic            halted_o
);

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;
    logic            halted_q, halted_d;

    logic load;
    logic accept;
    logic halt_hit;

    assign load     = fetch_en_i && !halted_q && !redirect_i && (!ir_valid_q || ir_ready_i);
    assign accept   = ir_valid_q && ir_ready_i;
    // Without the HALT option this folds to 0, so halted_q is a constant-0 register.
    assign halt_hit = HaltEn && (imem_data_i == HALT_OPCODE);

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;

        if (redirect_i) begin
            // Flush: any handshake on this edge has completed, the pending slot is emptied.
            pc_d       = redirect_pc_i;
            ir_valid_d = 1'b0;
            halted_d   = 1'b0;
        end else if (load) begin
            ir_d       = imem_data_i;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + PC_W'(1);
            if (halt_hit) begin
                halted_d = 1'b1;
            end
        end else if (accept) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            ir_q       <= 8'h00;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign ir_o        = ir_q;
    assign ir_pc_o     = ir_pc_q;
    assign ir_valid_o  = ir_valid_q;
    assign halted_o    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, back-pressure, redirect, wrap (PC_W=4), HALT, async reset.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic       fetch_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] ir;
    logic [7:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready;
    logic       halted;

    logic [3:0] imem_addr4;
    logic [7:0] imem_data4;
    logic [7:0] ir4;
    logic [3:0] ir_pc4;
    logic       ir_valid4;
    logic       halted4;

    logic [7:0] mem  [256];
    logic [7:0] mem4 [16];

    int n_vec = 0;
    int n_err = 0;

    assign imem_data  = mem[imem_addr];
    assign imem_data4 = mem4[imem_addr4];

    fetch_unit #(
        .PC_W(8),
        .RESET_PC(8'h00),
        .HALT_OPCODE(8'hFF)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .fetch_en_i(fetch_en),
        .imem_addr_o(imem_addr),
        .imem_data_i(imem_data),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .ir_o(ir),
        .ir_pc_o(ir_pc),
        .ir_valid_o(ir_valid),
        .ir_ready_i(ir_ready),
        .halted_o(halted)
    );

    fetch_unit #(
        .PC_W(4),
        .RESET_PC(4'hF),
        .HALT_OPCODE(8'hFF)
    ) u_dut4 (
        .clk_i(clk),
        .rst_i(rst),
        .fetch_en_i(fetch_en),
        .imem_addr_o(imem_addr4),
        .imem_data_i(imem_data4),
        .redirect_i(1'b0),
        .redirect_pc_i(4'h0),
        .ir_o(ir4),
        .ir_pc_o(ir_pc4),
        .ir_valid_o(ir_valid4),
        .ir_ready_i(1'b1),
        .halted_o(halted4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag, input logic [7:0] e_ir, input logic [7:0] e_pc,
                            input logic e_v, input logic [7:0] e_addr);
        check({tag, ".ir"}, 32'(ir), 32'(e_ir));
        check({tag, ".ir_pc"}, 32'(ir_pc), 32'(e_pc));
        check({tag, ".valid"}, 32'(ir_valid), 32'(e_v));
        check({tag, ".addr"}, 32'(imem_addr), 32'(e_addr));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55;
        mem[8'h10] = 8'hA5; mem[8'h11] = 8'hB6;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'hFF; mem[8'h23] = 8'h03;
        for (int i = 0; i < 16; i++) mem4[i] = 8'hC0 | 8'(i);
        mem4[15] = 8'hAF; mem4[0] = 8'hB0; mem4[1] = 8'hB1;

        rst = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        #2;
        check_ir("reset", 8'h00, 8'h00, 1'b0, 8'h00);
        check("reset.halted", 32'(halted), 32'd0);
        check("reset.addr4", 32'(imem_addr4), 32'hF);
        @(negedge clk);
        rst = 1'b0; fetch_en = 1'b1; ir_ready = 1'b1;

        // Stream with 4-bit wrap checked on the second instance in parallel.
        step();
        check_ir("s0", 8'h11, 8'h00, 1'b1, 8'h01);
        check("w0.ir_pc", 32'(ir_pc4), 32'hF);
        check("w0.ir", 32'(ir4), 32'hAF);
        check("w0.addr", 32'(imem_addr4), 32'h0);
        step();
        check_ir("s1", 8'h22, 8'h01, 1'b1, 8'h02);
        check("w1.ir_pc", 32'(ir_pc4), 32'h0);
        check("w1.ir", 32'(ir4), 32'hB0);
        ir_ready = 1'b0;
        step();
        check("w2.ir_pc", 32'(ir_pc4), 32'h1);
        check("w2.ir", 32'(ir4), 32'hB1);
        check_ir("bp0", 8'h22, 8'h01, 1'b1, 8'h02);
        step();
        check_ir("bp1", 8'h22, 8'h01, 1'b1, 8'h02);
        step();
        check_ir("bp2", 8'h22, 8'h01, 1'b1, 8'h02);
        ir_ready = 1'b1;
        step();
        check_ir("s2", 8'h33, 8'h02, 1'b1, 8'h03);
        step();
        check_ir("s3", 8'h44, 8'h03, 1'b1, 8'h04);

        // Redirect while stalled.
        ir_ready = 1'b0;
        step();
        check_ir("stall44", 8'h44, 8'h03, 1'b1, 8'h04);
        redirect = 1'b1; redirect_pc = 8'h10;
        step();
        check("rd.valid", 32'(ir_valid), 32'd0);
        check("rd.addr", 32'(imem_addr), 32'h10);
        redirect = 1'b0;
        step();
        check_ir("rd.tgt", 8'hA5, 8'h10, 1'b1, 8'h11);

        // fetch_en low: pending instruction is accepted, nothing new fetched.
        fetch_en = 1'b0; ir_ready = 1'b1;
        step();
        check_ir("fe0", 8'hA5, 8'h10, 1'b0, 8'h11);
        step();
        check_ir("fe1", 8'hA5, 8'h10, 1'b0, 8'h11);

        // HALT program at 0x20.
        fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 8'h20;
        step();
        check("h.rd.valid", 32'(ir_valid), 32'd0);
        redirect = 1'b0;
        step();
        check_ir("h0", 8'h01, 8'h20, 1'b1, 8'h21);
        step();
        check_ir("h1", 8'h02, 8'h21, 1'b1, 8'h22);
        step();
        check_ir("h2", 8'hFF, 8'h22, 1'b1, 8'h23);
`ifdef FETCH_HALT_EN
        check("h2.halted", 32'(halted), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_ir("hstop", 8'hFF, 8'h22, 1'b0, 8'h23);
            check("hstop.halted", 32'(halted), 32'd1);
        end
`else
        check("h2.halted", 32'(halted), 32'd0);
        step();
        check_ir("h3", 8'h03, 8'h23, 1'b1, 8'h24);
        check("h3.halted", 32'(halted), 32'd0);
`endif
        redirect = 1'b1; redirect_pc = 8'h20;
        step();
        check("hr.valid", 32'(ir_valid), 32'd0);
        check("hr.halted", 32'(halted), 32'd0);
        check("hr.addr", 32'(imem_addr), 32'h20);
        redirect = 1'b0;
        step();
        check_ir("hr.resume", 8'h01, 8'h20, 1'b1, 8'h21);

        // Asynchronous reset mid-cycle with a pending instruction at pc=5.
        redirect = 1'b1; redirect_pc = 8'h04;
        step();
        redirect = 1'b0;
        step();
        check_ir("pre_rst", 8'h55, 8'h04, 1'b1, 8'h05);
        #2;
        rst = 1'b1;
        #1;
        check_ir("async_rst", 8'h00, 8'h00, 1'b0, 8'h00);
        check("async_rst.halted", 32'(halted), 32'd0);
        check("async_rst.addr4", 32'(imem_addr4), 32'hF);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_ir("post_rst", 8'h11, 8'h00, 1'b1, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the custom 8-bit processor, sitting directly upstream of the combinational instruction memory. It owns the program counter, drives the memory address, and captures the returned byte into an instruction register. That register is presented to decode through a valid/ready handshake. It handles sequential increment, branch/jump redirects, decode back-pressure, and optional HALT detection.

## Interface
- PC_W, default 8: program counter and instruction-memory address width in bits.
- RESET_PC, default 0: PC value loaded on reset.
- HALT_OPCODE, default 8'hFF: opcode recognised as HALT (used only when FETCH_HALT_EN is defined).

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- fetch_en  input  1  global fetch enable; low freezes the PC and blocks new captures.
- imem_addr  output  PC_W  instruction-memory address; combinational copy of pc.
- imem_data  input  8  instruction byte returned combinationally by memory for imem_addr.
- redirect  input  1  single-cycle pulse; load redirect_pc and flush.
- redirect_pc  input  PC_W  redirect target.
- ir  output  8  captured instruction.
- ir_pc  output  PC_W  address ir was fetched from.
- ir_valid  output  1  ir holds an instruction not yet accepted by decode.
- ir_ready  input  1  decode accepts ir this cycle.
- halted  output  1  fetch stopped on HALT; constant 0 without FETCH_HALT_EN.

## Operation
- Reset values: pc=RESET_PC, ir=8'h00, ir_pc=0, ir_valid=0, halted=0.
- imem_addr = pc at all times, including during reset.
- Capture condition: `load = fetch_en && !halted && !redirect && (!ir_valid || ir_ready)`.
- On load:
  - ir<=imem_data, ir_pc<=pc, ir_valid<=1.
  - pc<=pc+1, modulo 2^PC_W: all-ones wraps to 0 with no flag.
- Accept without load (ir_valid && ir_ready && !load): ir_valid<=0, and ir/ir_pc hold their values.
- No load and no accept: pc, ir, ir_pc, and ir_valid all hold. ir must not change while ir_valid=1 and ir_ready=0.
- Redirect has the highest priority and is independent of fetch_en and ir_ready:
  - pc<=redirect_pc, ir_valid<=0, halted<=0.
  - A simultaneous ir_ready handshake completes normally on that edge.
  - The instruction at redirect_pc is captured on the next load edge.
- fetch_en low with ir_valid=1: the pending instruction can still be accepted. No new fetch occurs.

## Timing
- Fetch latency is one cycle: the instruction at pc A appears on ir, with ir_valid=1, at the edge where load is true while pc==A.
- Sustained throughput is one instruction per cycle while ir_ready=1 and fetch_en=1.
- Redirect penalty is one bubble: the edge after the redirect has ir_valid=0, and the target instruction is valid one edge later.
- Reset is asynchronous. Assertion mid-operation immediately forces all reset values, and any pending instruction is dropped. The first load occurs on the first rising edge after deassertion with fetch_en=1.
- There is no combinational path from ir_ready or redirect to imem_addr. imem_data→ir is the only memory-to-register path.

## Configuration
- FETCH_HALT_EN defined:
  - On a load where imem_data==HALT_OPCODE, ir takes the HALT opcode, ir_valid<=1, and halted<=1.
  - pc still increments past the HALT.
  - While halted=1, no further loads occur. The HALT instruction is presented once, and can be accepted normally.
  - halted clears only on redirect or reset.
- FETCH_HALT_EN undefined: halted is tied to 0, and HALT_OPCODE is fetched as an ordinary byte with no special behaviour.

## Test plan
- Reset then stream:
  - Stimulus: mem[0..3]=8'h11,22,33,44; fetch_en=1 and ir_ready=1 after reset release.
  - Required: ir shows 11,22,33,44 on consecutive edges with ir_pc 0..3 and ir_valid=1 from the first edge.
- Back-pressure:
  - Stimulus: ir_ready=0 for 3 cycles while ir=8'h22.
  - Required: ir, ir_pc=1, and ir_valid stay stable and pc stays at 2. After ir_ready rises, 8'h33 arrives on the next edge.
- Redirect:
  - Stimulus: redirect=1 with redirect_pc=8'h10 while stalled (ir_ready=0), mem[16]=8'hA5.
  - Required: the next edge has ir_valid=0 and pc=8'h10; the following edge has ir=A5 and ir_pc=8'h10.
- Wrap-around:
  - Stimulus: PC_W=4, start at pc=15.
  - Required: ir_pc sequence is 15, 0, 1, and imem_addr wraps to 0.
- HALT (FETCH_HALT_EN):
  - Stimulus: mem[2]=8'hFF.
  - Required: halted=1 after capturing it. ir=FF is accepted once, then ir_valid stays 0 for 5 or more cycles. A redirect to 0 clears halted and fetch resumes.
  - Same program without the macro: FF passes through, halted stays 0, and pc continues to 3.
- Mid-operation reset:
  - Stimulus: assert reset asynchronously between edges while ir_valid=1 and pc=5.
  - Required: ir_valid=0 and pc=RESET_PC immediately, without waiting for a clock edge.
